shift_arbiter: RTL and testbench

//  Shares one combinational Shift_Unit between two requesters: port 0 = integer

---
 rtl/shift_pkg.sv | 15 +
 rtl/Shift_Unit.sv | 30 +++
 rtl/shift_arbiter.sv | 131 +++++++++++++
 tb/tb_shift_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the shift arbiter: op codes as {funct7[5], funct3[2]},
// requester identifiers and the shift-amount width.
package shift_pkg;

  localparam logic [1:0] OP_SLL     = 2'b00;
  localparam logic [1:0] OP_SRL     = 2'b01;
  localparam logic [1:0] OP_ILLEGAL = 2'b10;
  localparam logic [1:0] OP_SRA     = 2'b11;

  localparam logic REQ_EXE = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  localparam int SHAMT_W = 5;

endpackage

// File: rtl/Shift_Unit.sv
// Combinational barrel shifter. Output is forced to zero when not enabled and
// for the illegal encoding, which is flagged instead of shifted.
module Shift_Unit
  import shift_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               en_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               f3_2_i,
  input  logic               f7_5_i,
  output logic [XLEN-1:0]    result_o,
  output logic               illegal_o
);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    if (en_i) begin
      case ({f7_5_i, f3_2_i})
        OP_SLL:     result_o = rs1_i << shamt_i;
        OP_SRL:     result_o = rs1_i >> shamt_i;
        OP_SRA:     result_o = $signed(rs1_i) >>> shamt_i;
        OP_ILLEGAL: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one Shift_Unit between the execute stage (port 0) and
// the CSR/bit-manip sequencer (port 1), with a single registered result stage.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [XLEN-1:0]    req_rs1_0,
  input  logic [XLEN-1:0]    req_rs1_1,
  input  logic [SHAMT_W-1:0] req_shamt_0,
  input  logic [SHAMT_W-1:0] req_shamt_1,
  input  logic               req_f3_2_0,
  input  logic               req_f3_2_1,
  input  logic               req_f7_5_0,
  input  logic               req_f7_5_1,
  input  logic [TAG_W-1:0]   req_tag_0,
  input  logic [TAG_W-1:0]   req_tag_1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [XLEN-1:0]    res_data,
  output logic               res_id,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_illegal
);

  logic              rr_ptr_q, rr_ptr_d;
  logic              res_valid_q, res_valid_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic              res_id_q, res_id_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              res_illegal_q, res_illegal_d;

  logic [1:0]         grant;
  logic               can_accept;
  logic               xfer;
  logic               winner;
  logic [XLEN-1:0]    sel_rs1;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_f3_2;
  logic               sel_f7_5;
  logic [TAG_W-1:0]   sel_tag;
  logic [XLEN-1:0]    shift_result;
  logic               shift_illegal;

  // rr_ptr only matters when both requesters contend.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant[REQ_EXE] = 1'b1;
      2'b10:   grant[REQ_AUX] = 1'b1;
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign can_accept = rst_n & ~flush & (~res_valid_q | res_ready);
  assign req_ready  = can_accept ? grant : 2'b00;
  assign xfer       = |(req_valid & req_ready);
  assign winner     = grant[REQ_AUX];

  assign sel_rs1   = winner ? req_rs1_1   : req_rs1_0;
  assign sel_shamt = winner ? req_shamt_1 : req_shamt_0;
  assign sel_f3_2  = winner ? req_f3_2_1  : req_f3_2_0;
  assign sel_f7_5  = winner ? req_f7_5_1  : req_f7_5_0;
  assign sel_tag   = winner ? req_tag_1   : req_tag_0;

  Shift_Unit #(
    .XLEN(XLEN)
  ) u_shift (
    .en_i     (xfer),
    .rs1_i    (sel_rs1),
    .shamt_i  (sel_shamt),
    .f3_2_i   (sel_f3_2),
    .f7_5_i   (sel_f7_5),
    .result_o (shift_result),
    .illegal_o(shift_illegal)
  );

  // A consume and a new transfer in the same cycle keep res_valid high.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_id_d      = res_id_q;
    res_tag_d     = res_tag_q;
    res_illegal_d = res_illegal_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (xfer) begin
      res_valid_d   = 1'b1;
      res_data_d    = shift_result;
      res_id_d      = winner;
      res_tag_d     = sel_tag;
      res_illegal_d = shift_illegal;
      rr_ptr_d      = ~winner;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      rr_ptr_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_id_q      <= 1'b0;
      res_tag_q     <= '0;
      res_illegal_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_id_q      <= res_id_d;
      res_tag_q     <= res_tag_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_id      = res_id_q;
  assign res_tag     = res_tag_q;
  assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized checks of shift_arbiter against a transaction-level
// model whose shift results come from plain integer arithmetic.
module tb_shift_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_rs1_0, req_rs1_1;
  logic [4:0]  req_shamt_0, req_shamt_1;
  logic        req_f3_2_0, req_f3_2_1;
  logic        req_f7_5_0, req_f7_5_1;
  logic [3:0]  req_tag_0, req_tag_1;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;
  logic [3:0]  res_tag;
  logic        res_illegal;

  always #5 CLK = ~CLK;

  shift_arbiter #(.XLEN(32), .TAG_W(4)) dut (
    .CLK(CLK), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .req_f3_2_0(req_f3_2_0), .req_f3_2_1(req_f3_2_1),
    .req_f7_5_0(req_f7_5_0), .req_f7_5_1(req_f7_5_1),
    .req_tag_0(req_tag_0), .req_tag_1(req_tag_1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_tag(res_tag),
    .res_illegal(res_illegal)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what the result register should hold, plus the fairness pointer.
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  bit          m_id    = 1'b0;
  logic [3:0]  m_tag   = '0;
  bit          m_ill   = 1'b0;
  bit          m_rr    = 1'b0;
  bit   [1:0]  acc     = 2'b00;

  function automatic logic [31:0] ref_shift(logic [31:0] a, int sh, bit f3, bit f7);
    longint p = 1;
    longint v;
    longint q;
    for (int k = 0; k < sh % 32; k++) p = p * 2;
    if (!f7 && !f3) return 32'(longint'(a) * p);
    if (!f7 && f3)  return 32'(longint'(a) / p);
    if (f7 && f3) begin
      v = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
      q = v / p;
      if (v < 0 && (v % p) != 0) q = q - 1;
      return 32'(q);
    end
    return 32'h0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pay(int i, logic [31:0] rs1, logic [4:0] sh, bit f3, bit f7, logic [3:0] tag);
    if (i == 0) begin
      req_rs1_0 = rs1; req_shamt_0 = sh; req_f3_2_0 = f3; req_f7_5_0 = f7; req_tag_0 = tag;
    end else begin
      req_rs1_1 = rs1; req_shamt_1 = sh; req_f3_2_1 = f3; req_f7_5_1 = f7; req_tag_1 = tag;
    end
  endtask

  // One clock: check the handshake, advance the model, check the registered outputs.
  task automatic step();
    bit          can;
    int          win;
    logic [1:0]  exp_ready;
    #1;
    can = rst_n && !flush && (!m_valid || res_ready);
    win = -1;
    if (req_valid == 2'b11) win = int'(m_rr);
    else if (req_valid[0])  win = 0;
    else if (req_valid[1])  win = 1;
    exp_ready = (can && win >= 0) ? 2'(1 << win) : 2'b00;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = exp_ready;
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_id = 0; m_tag = '0; m_ill = 0; m_rr = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (exp_ready != 2'b00) begin
      m_valid = 1;
      m_id    = (win == 1);
      if (win == 0) begin
        m_data = ref_shift(req_rs1_0, int'(req_shamt_0), req_f3_2_0, req_f7_5_0);
        m_ill  = (req_f7_5_0 && !req_f3_2_0);
        m_tag  = req_tag_0;
      end else begin
        m_data = ref_shift(req_rs1_1, int'(req_shamt_1), req_f3_2_1, req_f7_5_1);
        m_ill  = (req_f7_5_1 && !req_f3_2_1);
        m_tag  = req_tag_1;
      end
      m_rr = (win == 0);
      $display("xfer t=%0t id=%0d tag=%0d data=%h illegal=%0d", $time, win, m_tag, m_data, m_ill);
    end else if (res_ready) begin
      m_valid = 0;
    end
    @(posedge CLK);
    #1;
    chk("res_valid",   32'(res_valid),   32'(m_valid));
    chk("res_data",    res_data,         m_data);
    chk("res_id",      32'(res_id),      32'(m_id));
    chk("res_tag",     32'(res_tag),     32'(m_tag));
    chk("res_illegal", 32'(res_illegal), 32'(m_ill));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b1; req_valid = 2'b11;
    set_pay(0, 32'h8000_00F0, 5'd4, 1'b1, 1'b1, 4'd3);
    set_pay(1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 4'd5);
    @(posedge CLK); #1;

    // Reset held with both requesters valid
    repeat (3) step();
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_data", res_data, 32'h0);

    // First grant after reset goes to requester 0 (SRA), then requester 1 (SLL)
    rst_n = 1'b1;
    step();
    chk("t2_id", 32'(res_id), 32'h0);
    chk("t2_data", res_data, 32'hF800_000F);
    chk("t2_tag", 32'(res_tag), 32'h3);
    set_pay(0, 32'h1234_5678, 5'd8, 1'b0, 1'b0, 4'd7);
    step();
    chk("t3_id", 32'(res_id), 32'h1);
    chk("t3_data", res_data, 32'h8000_0000);
    repeat (4) step();

    // Backpressure with a held result, then release
    res_ready = 1'b0;
    repeat (4) step();
    res_ready = 1'b1;
    step();

    // Illegal encoding and shift-amount boundaries
    req_valid = 2'b01;
    set_pay(0, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, 4'd9);
    step();
    chk("ill_flag", 32'(res_illegal), 32'h1);
    chk("ill_data", res_data, 32'h0);
    set_pay(0, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 4'd10);
    step();
    chk("srl0", res_data, 32'hFFFF_FFFF);
    set_pay(0, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 4'd11);
    step();
    chk("srl31", res_data, 32'h0000_0001);

    // Flush with a result held and both requesters valid, then resume
    req_valid = 2'b11;
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(res_valid), 32'h0);
    flush = 1'b0;
    repeat (2) step();

    // Reset in the middle of backpressure
    res_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(res_valid), 32'h0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    req_valid = 2'b00;
    step();

    // Randomized traffic; payload held stable until accepted
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 15) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = $urandom_range(0, 1) == 1;
          set_pay(i, $urandom, 5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
